scn_layer_shifter: RTL
======================

SCN_LAYER_SHIFTER -- requirements
Module: scn_layer_shifter

Interface
REQ-001 Parameter NUM_LAYERS, default 3, number of independent tile layers (1..4).
REQ-002 Parameter PIXEL_WIDTH, default 4, bits per pen.
REQ-003 Parameter PALETTE_WIDTH, default 8, bits per tile palette/attribute.
REQ-004 Derived DOT_WIDTH = PALETTE_WIDTH + PIXEL_WIDTH; all layer buses are flat, with layer L at slice [L*w +: w].
REQ-005 clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ce_pixel  in  1  pixel-rate clock enable.
REQ-008 load  in  1  column-boundary strobe, qualified by ce_pixel.
REQ-009 in_valid  in  NUM_LAYERS  per-layer staging write request.
REQ-010 in_ready  out  NUM_LAYERS  per-layer staging buffer empty.
REQ-011 in_gfx  in  NUM_LAYERS*8*PIXEL_WIDTH  tile row; pixel i at [i*PIXEL_WIDTH +: PIXEL_WIDTH], pixel 0 leftmost.
REQ-012 in_palette  in  NUM_LAYERS*PALETTE_WIDTH  tile palette.
REQ-013 in_flipx  in  NUM_LAYERS  mirror tile row horizontally.
REQ-014 tap  in  NUM_LAYERS*3  per-layer fine horizontal scroll 0..7.
REQ-015 layer_en  in  NUM_LAYERS  layer enable mask.
REQ-016 prio_swap  in  1  exchange priority of layers 0 and 1.
REQ-017 dot_out  out  DOT_WIDTH  mixed {palette, pen}.
REQ-018 dot_layer  out  2  index of the winning layer.
REQ-019 dot_opaque  out  1  a non-transparent layer won.
REQ-020 underrun  out  NUM_LAYERS  sticky flag: load found the staging buffer empty.

Function
REQ-021 Each layer SHALL hold a 1-entry staging buffer (gfx, palette, flipx, full flag); in_ready[L] = ~full[L], combinational from the flag only.
REQ-022 in_valid[L] & in_ready[L] at a clock edge SHALL capture the data and set full; ce_pixel is not required for the capture.
REQ-023 Each layer SHALL hold a 16-dot window S[0..15]; on every ce_pixel, S[k] <= S[k+1] for k = 0..14.
REQ-024 On ce_pixel & load, the staged row SHALL be written into S[8..15]; with flipx=0 pixel i goes to S[8+i], with flipx=1 pixel 7-i goes to S[8+i]; each entry is {palette, pen}; full is cleared.
REQ-025 On ce_pixel & load with full=0, S[8..15] SHALL be written with zeros and underrun[L] set.
REQ-026 If in_valid is asserted on the same edge as a load, the load SHALL use the pre-edge buffer contents; a capture into an empty buffer on that edge SHALL not count toward the load (underrun still sets) and SHALL leave full=1.
REQ-027 A layer's candidate dot SHALL be S[tap[L]] sampled before the edge; a pen of 0 is transparent.
REQ-028 Priority SHALL follow the natural order 0,1,2,3 (lowest index on top); prio_swap=1 SHALL place layer 1 above layer 0, with the other layers unchanged.
REQ-029 The winner SHALL be the highest-priority layer with layer_en=1 and a non-zero pen.
REQ-030 If no layer qualifies, dot_out=0, dot_layer=0 and dot_opaque=0.
REQ-031 dot_out, dot_layer and dot_opaque SHALL be registered and update only on ce_pixel, giving a latency of exactly one ce_pixel from window state to output.
REQ-032 A load without ce_pixel SHALL be ignored; a tap change SHALL take effect at the next ce_pixel with no glitch.
REQ-033 underrun[L] SHALL clear only on reset.

Reset
REQ-034 On reset, all windows, staging buffers, full flags, underrun, dot_out, dot_layer and dot_opaque SHALL be 0, and in_ready SHALL be all-ones the cycle after reset.
REQ-035 Reset SHALL take priority over simultaneous load, in_valid and ce_pixel, and SHALL abandon any staged row.

Structure
REQ-036 A shared package scn_pkg SHALL hold TRANSPARENT_PEN=0, TILE_DOTS=8, WINDOW_DOTS=16, and a function that flips a row.
REQ-037 One sub-module, scn_dot_shifter, SHALL contain the per-layer staging buffer, window and underrun flag, instantiated NUM_LAYERS times by generate; the mixer SHALL live in the top module.

Verification
REQ-038 Stage layer 0 with gfx pens 1..8, palette 0x12, flipx=0, tap=0, then run 16 ce_pixel with load every 8th -> after the second load, dot_out reads 0x121..0x128 on consecutive ce_pixel.
REQ-039 Repeat REQ-038 with flipx=1 and tap=3 -> the pen sequence is 8..1 and starts 3 ce_pixel earlier within the window.
REQ-040 Leave layer 1 unstaged and issue a load -> underrun=2'b10, layer 1 emits transparent, and in_ready[1] stays 1.
REQ-041 Layer 0 pen 5 over layer 1 pen 9 -> dot_layer=0; with prio_swap=1 -> dot_layer=1; with layer_en=2'b01 and the layer 0 pen set to 0 -> dot_opaque=0.
REQ-042 Assert in_valid on an empty buffer in the same cycle as ce_pixel & load -> underrun sets, full=1 after the edge, and the next load uses the captured data.
REQ-043 Assert reset mid-row with full=1 -> the next cycle shows in_ready=all-ones, dot_out=0 and underrun=0.

Source files
------------

// File: rtl/scn_pkg.sv
// Shared constants and helpers for the scanline tile-layer shifter.
// Rows are carried zero-extended to MAX_PEN_W bits per pen so one flip function serves any width.
package scn_pkg;

   localparam int unsigned TRANSPARENT_PEN = 0;
   localparam int unsigned TILE_DOTS       = 8;
   localparam int unsigned WINDOW_DOTS     = 16;
   localparam int unsigned MAX_PEN_W       = 16;

   typedef logic [TILE_DOTS*MAX_PEN_W-1:0] row_t;

   // Mirror a tile row; pen_w is the real pen width packed in the low bits.
   function automatic row_t flip_row(input row_t row, input int unsigned pen_w);
      row_t r;
      r = '0;
      for (int i = 0; i < TILE_DOTS; i++) begin
         for (int b = 0; b < MAX_PEN_W; b++) begin
            if (b < pen_w) begin
               r[(TILE_DOTS - 1 - i) * pen_w + b] = row[i * pen_w + b];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/scn_dot_shifter.sv
// One tile layer: single-entry staging buffer, 16-dot shift window and sticky underrun flag.
// The candidate dot is the pre-edge window entry selected by the fine-scroll tap.
module scn_dot_shifter
   import scn_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH   = 4,
   parameter int unsigned PALETTE_WIDTH = 8,
   localparam int unsigned DOT_WIDTH    = PALETTE_WIDTH + PIXEL_WIDTH,
   localparam int unsigned GFX_WIDTH    = TILE_DOTS * PIXEL_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ce_pixel,
   input  logic                     load,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [GFX_WIDTH-1:0]     in_gfx,
   input  logic [PALETTE_WIDTH-1:0] in_palette,
   input  logic                     in_flipx,
   input  logic [2:0]               tap,
   output logic [DOT_WIDTH-1:0]     cand,
   output logic                     underrun
);

   logic [GFX_WIDTH-1:0]     gfx_q;
   logic [PALETTE_WIDTH-1:0] pal_q;
   logic                     flip_q;
   logic                     full_q, full_d;
   logic                     underrun_q, underrun_d;
   logic [DOT_WIDTH-1:0]     win_q [WINDOW_DOTS];
   logic [DOT_WIDTH-1:0]     win_d [WINDOW_DOTS];
   logic [GFX_WIDTH-1:0]     row;
   row_t                     row_wide;
   logic                     do_load;
   logic                     capture;

   assign do_load  = ce_pixel & load;
   assign capture  = in_valid & ~full_q;
   assign in_ready = ~full_q;
   assign underrun = underrun_q;
   assign cand     = win_q[{1'b0, tap}];

   always_comb begin
      row_wide = flip_q ? flip_row(row_t'(gfx_q), PIXEL_WIDTH) : row_t'(gfx_q);
      row      = row_wide[GFX_WIDTH-1:0];
   end

   // A load consumes the pre-edge buffer; a same-edge capture refills it afterwards.
   always_comb begin
      full_d     = full_q;
      underrun_d = underrun_q;
      if (do_load) begin
         full_d = 1'b0;
         if (!full_q) begin
            underrun_d = 1'b1;
         end
      end
      if (capture) begin
         full_d = 1'b1;
      end
   end

   always_comb begin
      for (int k = 0; k < WINDOW_DOTS; k++) begin
         win_d[k] = win_q[k];
      end
      if (ce_pixel) begin
         for (int k = 0; k < WINDOW_DOTS - 1; k++) begin
            win_d[k] = win_q[k+1];
         end
         win_d[WINDOW_DOTS-1] = '0;
         if (load) begin
            for (int i = 0; i < TILE_DOTS; i++) begin
               win_d[TILE_DOTS+i] = full_q ? {pal_q, row[i*PIXEL_WIDTH +: PIXEL_WIDTH]} : '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gfx_q      <= '0;
         pal_q      <= '0;
         flip_q     <= 1'b0;
         full_q     <= 1'b0;
         underrun_q <= 1'b0;
         for (int k = 0; k < WINDOW_DOTS; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         full_q     <= full_d;
         underrun_q <= underrun_d;
         for (int k = 0; k < WINDOW_DOTS; k++) begin
            win_q[k] <= win_d[k];
         end
         if (capture) begin
            gfx_q  <= in_gfx;
            pal_q  <= in_palette;
            flip_q <= in_flipx;
         end
      end
   end

endmodule

// File: rtl/scn_layer_shifter.sv
// Multi-layer tile shifter with priority mixer; the mixed dot is registered on ce_pixel.
// Layer 0 is on top unless prio_swap lifts layer 1 above it.
module scn_layer_shifter
   import scn_pkg::*;
#(
   parameter int unsigned NUM_LAYERS    = 3,
   parameter int unsigned PIXEL_WIDTH   = 4,
   parameter int unsigned PALETTE_WIDTH = 8,
   localparam int unsigned DOT_WIDTH    = PALETTE_WIDTH + PIXEL_WIDTH,
   localparam int unsigned GFX_WIDTH    = TILE_DOTS * PIXEL_WIDTH
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                ce_pixel,
   input  logic                                load,
   input  logic [NUM_LAYERS-1:0]               in_valid,
   output logic [NUM_LAYERS-1:0]               in_ready,
   input  logic [NUM_LAYERS*GFX_WIDTH-1:0]     in_gfx,
   input  logic [NUM_LAYERS*PALETTE_WIDTH-1:0] in_palette,
   input  logic [NUM_LAYERS-1:0]               in_flipx,
   input  logic [NUM_LAYERS*3-1:0]             tap,
   input  logic [NUM_LAYERS-1:0]               layer_en,
   input  logic                                prio_swap,
   output logic [DOT_WIDTH-1:0]                dot_out,
   output logic [1:0]                          dot_layer,
   output logic                                dot_opaque,
   output logic [NUM_LAYERS-1:0]               underrun
);

   logic [NUM_LAYERS*DOT_WIDTH-1:0] cand;
   logic [DOT_WIDTH-1:0]            dot_q, dot_d;
   logic [1:0]                      layer_q, layer_d;
   logic                            opaque_q, opaque_d;

   for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
      scn_dot_shifter #(
         .PIXEL_WIDTH   (PIXEL_WIDTH),
         .PALETTE_WIDTH (PALETTE_WIDTH)
      ) u_shifter (
         .clk        (clk),
         .reset      (reset),
         .ce_pixel   (ce_pixel),
         .load       (load),
         .in_valid   (in_valid[l]),
         .in_ready   (in_ready[l]),
         .in_gfx     (in_gfx[l*GFX_WIDTH +: GFX_WIDTH]),
         .in_palette (in_palette[l*PALETTE_WIDTH +: PALETTE_WIDTH]),
         .in_flipx   (in_flipx[l]),
         .tap        (tap[l*3 +: 3]),
         .cand       (cand[l*DOT_WIDTH +: DOT_WIDTH]),
         .underrun   (underrun[l])
      );
   end

   // Walk from lowest to highest priority so the last qualifying layer wins.
   always_comb begin
      int                   idx;
      logic [DOT_WIDTH-1:0] c;
      idx      = 0;
      c        = '0;
      dot_d    = '0;
      layer_d  = '0;
      opaque_d = 1'b0;
      for (int p = int'(NUM_LAYERS) - 1; p >= 0; p--) begin
         idx = p;
         if (prio_swap && NUM_LAYERS > 1 && p < 2) begin
            idx = 1 - p;
         end
         c = cand[idx*DOT_WIDTH +: DOT_WIDTH];
         if (layer_en[idx] && c[PIXEL_WIDTH-1:0] != PIXEL_WIDTH'(TRANSPARENT_PEN)) begin
            dot_d    = c;
            layer_d  = 2'(idx);
            opaque_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dot_q    <= '0;
         layer_q  <= '0;
         opaque_q <= 1'b0;
      end else if (ce_pixel) begin
         dot_q    <= dot_d;
         layer_q  <= layer_d;
         opaque_q <= opaque_d;
      end
   end

   assign dot_out    = dot_q;
   assign dot_layer  = layer_q;
   assign dot_opaque = opaque_q;

endmodule
